// File: rtl/seq_detect_masked_if.sv
// rtl/seq_detect_masked_if.sv - serial bit stream in, match pulse and count out
interface seq_detect_masked_if #(
    parameter int CNT_W = 8
);
    logic             a_valid;
    logic             a;
    logic             match;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output a_valid,
        output a,
        input  match,
        input  match_cnt
    );

    modport slave (
        input  a_valid,
        input  a,
        output match,
        output match_cnt
    );
endinterface

// File: rtl/seq_detect_masked.sv
// rtl/seq_detect_masked.sv - masked programmable serial sequence detector
// Optional match counter enabled by SEQ_DETECT_MATCH_CNT_EN; otherwise match_cnt is tied to 0.
module seq_detect_masked #(
    parameter int SEQ_LEN = 9,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    seq_detect_masked_if.slave s,
    input  logic [SEQ_LEN-1:0] cfg_pattern,
    input  logic [SEQ_LEN-1:0] cfg_mask,
    input  logic               cfg_overlap
);
    localparam int                FILL_W    = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(SEQ_LEN);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

    logic [SEQ_LEN-1:0] history;
    logic [FILL_W-1:0]  fill;
    logic               new_flag;
    logic               match_q;
    logic               hit;

    // Only a freshly shifted bit on a fully populated history may complete a sequence.
    assign hit = new_flag && (fill == FILL_FULL) &&
                 (((history ^ cfg_pattern) & cfg_mask) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            history  <= '0;
            fill     <= '0;
            new_flag <= 1'b0;
            match_q  <= 1'b0;
        end else if (clr) begin
            history  <= '0;
            fill     <= '0;
            new_flag <= 1'b0;
            match_q  <= 1'b0;
        end else begin
            if (s.a_valid) begin
                history <= {history[SEQ_LEN-2:0], s.a};
            end
            new_flag <= s.a_valid;
            match_q  <= hit;
            // Non-overlapping: restart the fill so the next match needs a full fresh window.
            if (hit && !cfg_overlap) begin
                fill <= s.a_valid ? FILL_ONE : '0;
            end else if (s.a_valid && (fill != FILL_FULL)) begin
                fill <= fill + FILL_ONE;
            end
        end
    end

    assign s.match = match_q;

`ifdef SEQ_DETECT_MATCH_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (hit && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign s.match_cnt = cnt;
`else
    assign s.match_cnt = {CNT_W{1'b0}};
`endif
endmodule

// File: doc/seq_detect_masked.md
Name: seq_detect_masked

Overview:
- Parametrised serial-bit sequence detector; successor to the fixed 9-bit don't-care detector.
- Adds the following over that detector:
  - Runtime-programmable pattern and per-bit compare mask.
  - Input-valid qualifier.
  - Overlapping or non-overlapping detection mode.
  - Fill tracking, so there are no false matches right after reset.
  - Synchronous clear and a saturating match counter.
- Sits on a 1-bit serial data stream; the match pulse feeds control logic or an interrupt aggregator.

Parameters:
- SEQ_LEN, 9, pattern length in bits (>= 2).
- CNT_W, 8, width of the saturating match counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear of history, fill, match and counter.
- a_valid  input  1  a is a new stream bit this cycle.
- a  input  1  serial data bit.
- cfg_pattern  input  SEQ_LEN  expected sequence; bit SEQ_LEN-1 = oldest bit.
- cfg_mask  input  SEQ_LEN  1 = compare this position, 0 = don't care.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- match  output  1  registered one-cycle pulse per detected sequence.
- match_cnt  output  CNT_W  number of matches, saturating.

Behaviour:
- Reset: clock is clk; reset is rst_n, asynchronous, active-low. All of the following clear to 0:
  - history shift register (SEQ_LEN bits), fill counter, new-bit flag, match, match_cnt.
- History update: on a clk edge with a_valid=1, history <= {history[SEQ_LEN-2:0], a}. The new bit enters at bit 0.
- Fill counter:
  - Increments on each accepted bit and saturates at SEQ_LEN.
  - history_full = (fill == SEQ_LEN).
- New-bit flag: registered copy of a_valid (after clr gating).
- Evaluation: on each edge,
  - match <= new_flag & history_full & (((history ^ cfg_pattern) & cfg_mask) == 0).
  - cfg_* are sampled at this evaluation edge; they are quasi-static and not registered.
- Latency: the completing bit is sampled at edge k; match is high for exactly the cycle after edge k+1.
- No repeats without new data: match is never re-asserted unless a new bit arrived. Idle cycles (a_valid=0) hold history and produce match=0.
- Overlap mode (cfg_overlap=1): history is not disturbed by a match. Consecutive bits may each produce a match.
- Non-overlap mode (cfg_overlap=0): on the edge where match is set to 1, fill is reset.
  - If a_valid=1 on that same edge, the bit is shifted in and fill becomes 1; otherwise fill becomes 0.
  - A further match therefore needs SEQ_LEN fresh bits.
- Mask all zero: matches on every new bit once history is full (overlap mode).
- Counter:
  - match_cnt increments by 1 on each edge where match is set to 1.
  - It holds at 2^CNT_W-1 and does not wrap.
- clr=1 (synchronous):
  - Clears history, fill, new flag, match and match_cnt on that edge.
  - Has priority over a_valid: a bit presented with clr is discarded.
- Reset mid-sequence: partial history is lost and the full SEQ_LEN bits are required again.

Optional Feature:
- Macro: SEQ_DETECT_MATCH_CNT_EN.
- Defined: match_cnt logic is implemented as above.
- Undefined: counter logic is removed and the match_cnt port is tied to 0. All other behaviour is unchanged.

Test Plan:
- Basic masked match. Setup: SEQ_LEN=9, pattern=9'b011000110, mask=9'b111000111, overlap=1. Stimulus: bits 0,1,1,1,0,1,1,1,0 (oldest first), one per cycle with a_valid=1. Response: a single match pulse the cycle after the 9th bit's edge+1; match_cnt=1.
- Fill guard. Setup: after reset, mask=0. Stimulus: 8 valid bits. Response: match=0 throughout. Then: the 9th bit gives a match, and each further bit gives another match; match_cnt=3 after 11 bits.
- Overlap versus non-overlap. Setup: pattern=9'b101010101, mask=all 1s. Stimulus: stream 1,0,1,0,1,0,1,0,1,0,1.
  - overlap=1: 2 matches (bits 9 and 11).
  - overlap=0: 1 match (bit 9 only).
- Valid gaps. Stimulus: the basic-match stream with a_valid=0 idle cycles after bits 3 and 7. Response: exactly one match pulse, following the 9th valid bit; no pulse during idle cycles.
- Saturation and clear. Setup: CNT_W=2, mask=0, overlap=1, history full. Stimulus: 6 valid bits give 6 matches. Response: match_cnt stays at 3. Then: clr with a_valid=1 gives match_cnt=0 and fill=0; 8 more bits give no match.
- Async reset mid-op. Stimulus: assert rst_n=0 between bits 5 and 6 of the basic stream. Response: match and match_cnt go to 0 immediately. Replaying only bits 6-9 after release gives no match.
